// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: ALU (valid/ready) vs. load FIFO, round-robin, registered write stage.
// Optional saturating grant counters are enabled with `define WB_COUNT_EN.
module reg_wb_arbiter #(
   parameter int W     = 9,
   parameter int AW    = 2,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            alu_req,
   input  logic [AW-1:0]   alu_addr,
   input  logic [W-1:0]    alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_addr,
   input  logic [W-1:0]    mem_data,
   output logic            mem_full,
   output logic            overflow,
   output logic            write,
   output logic [AW-1:0]   rd_addr,
   output logic [W-1:0]    rd_in,
   output logic [2**AW-1:0] busy
`ifdef WB_COUNT_EN
   ,
   output logic [7:0]      alu_cnt,
   output logic [7:0]      mem_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {PTR_MEM = 1'b0, PTR_ALU = 1'b1} ptr_e;

   ptr_e            ptr_q, ptr_d;
   logic [AW-1:0]   fa_q [DEPTH];
   logic [W-1:0]    fd_q [DEPTH];
   logic [DEPTH-1:0] fv_q, fv_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            write_q, write_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [W-1:0]    rd_in_q, rd_in_d;
   logic            fifo_ne, fifo_full, gm, ga, push, contended;

   always_comb begin
      fifo_ne   = (count_q != '0);
      fifo_full = (count_q == CW'(DEPTH));
      gm        = !stall && fifo_ne && (!alu_req || ptr_q == PTR_MEM || fifo_full);
      ga        = !stall && alu_req && !gm;
      alu_ready = !stall && !(fifo_ne && (ptr_q == PTR_MEM || fifo_full));
      // A full FIFO may still accept a load when its head leaves in the same cycle.
      push      = mem_valid && (!fifo_full || gm);
      contended = !stall && fifo_ne && alu_req;

      ptr_d = ptr_q;
      if (contended) ptr_d = gm ? PTR_ALU : PTR_MEM;

      ovf_d = ovf_q | (mem_valid && !push);

      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      fv_d     = fv_q;
      if (gm) begin
         rd_ptr_d       = rd_ptr_q + PW'(1);
         fv_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
         wr_ptr_d       = wr_ptr_q + PW'(1);
         fv_d[wr_ptr_q] = 1'b1;
      end
      if (push && !gm)      count_d = count_q + CW'(1);
      else if (!push && gm) count_d = count_q - CW'(1);

      write_d   = gm || ga;
      rd_addr_d = rd_addr_q;
      rd_in_d   = rd_in_q;
      if (gm) begin
         rd_addr_d = fa_q[rd_ptr_q];
         rd_in_d   = fd_q[rd_ptr_q];
      end else if (ga) begin
         rd_addr_d = alu_addr;
         rd_in_d   = alu_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= PTR_MEM;
         fv_q      <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         write_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_in_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         fv_q      <= fv_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         write_q   <= write_d;
         rd_addr_q <= rd_addr_d;
         rd_in_q   <= rd_in_d;
      end
   end

   // Entry payload needs no reset: the valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         fa_q[wr_ptr_q] <= mem_addr;
         fd_q[wr_ptr_q] <= mem_data;
      end
   end

   for (genvar gi = 0; gi < 2**AW; gi++) begin : g_busy
      logic [DEPTH-1:0] hit;
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
         assign hit[gj] = fv_q[gj] && (fa_q[gj] == AW'(gi));
      end
      assign busy[gi] = (|hit) || (write_q && rd_addr_q == AW'(gi));
   end

   assign mem_full = fifo_full;
   assign overflow = ovf_q;
   assign write    = write_q;
   assign rd_addr  = rd_addr_q;
   assign rd_in    = rd_in_q;

`ifdef WB_COUNT_EN
   logic [7:0] alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;

   always_comb begin
      alu_cnt_d = alu_cnt_q;
      mem_cnt_d = mem_cnt_q;
      if (ga && alu_cnt_q != 8'hFF) alu_cnt_d = alu_cnt_q + 8'd1;
      if (gm && mem_cnt_q != 8'hFF) mem_cnt_d = mem_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_cnt_q <= '0;
         mem_cnt_q <= '0;
      end else begin
         alu_cnt_q <= alu_cnt_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

   assign alu_cnt = alu_cnt_q;
   assign mem_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: a queue-based model predicts each cycle's write stage,
// a separate monitor pops and compares after every clock edge.
module tb_reg_wb_arbiter;
   localparam int W = 9, AW = 2, DEPTH = 2;

   logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
   logic alu_req = 1'b0, mem_valid = 1'b0;
   logic [AW-1:0] alu_addr = '0, mem_addr = '0, rd_addr;
   logic [W-1:0] alu_data = '0, mem_data = '0, rd_in;
   logic alu_ready, mem_full, overflow, write;
   logic [2**AW-1:0] busy;
`ifdef WB_COUNT_EN
   logic [7:0] alu_cnt, mem_cnt;
`endif

   reg_wb_arbiter #(.W(W), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_full(mem_full), .overflow(overflow),
      .write(write), .rd_addr(rd_addr), .rd_in(rd_in), .busy(busy)
`ifdef WB_COUNT_EN
      , .alu_cnt(alu_cnt), .mem_cnt(mem_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {logic wr; logic [AW-1:0] a; logic [W-1:0] d;} exp_t;
   typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} ld_t;

   exp_t sb[$];
   ld_t  mq[$];
   bit   mem_turn;
   bit   m_ovf;
   exp_t m_ws;
   int   m_acnt, m_mcnt;
   int   checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      mem_turn = 1'b1;
      m_ovf    = 1'b0;
      m_ws     = '0;
      m_acnt   = 0;
      m_mcnt   = 0;
   endtask

   // Monitor: after each rising edge the write stage must match the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("write", write, e.wr);
            chk("rd_addr", rd_addr, e.a);
            chk("rd_in", rd_in, e.d);
            if (write) $display("WB t=%0t addr=%0d data=%03h", $time, rd_addr, rd_in);
         end
      end
   end

   task automatic cycle(input bit st, input bit ar, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                        input bit mv, input logic [AW-1:0] ma, input logic [W-1:0] md);
      int n;
      bit full, mem_ok, alu_ok, gm, ga, exp_ready;
      logic [2**AW-1:0] exp_busy;
      ld_t h;
      @(negedge clk);
      stall = st; alu_req = ar; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      #3;
      n      = mq.size();
      full   = (n == DEPTH);
      mem_ok = !st && n > 0;
      alu_ok = !st && ar;
      gm     = mem_ok && (!ar || mem_turn || full);
      ga     = alu_ok && !gm;
      exp_ready = !st && !(n > 0 && (mem_turn || full));
      exp_busy = '0;
      foreach (mq[i]) exp_busy[mq[i].a] = 1'b1;
      if (m_ws.wr) exp_busy[m_ws.a] = 1'b1;
      chk("alu_ready", alu_ready, exp_ready);
      chk("mem_full", mem_full, full);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, exp_busy);
`ifdef WB_COUNT_EN
      chk("alu_cnt", alu_cnt, m_acnt);
      chk("mem_cnt", mem_cnt, m_mcnt);
`endif
      if (mem_ok && alu_ok) mem_turn = ga;
      m_ws.wr = gm || ga;
      if (gm) begin
         h = mq.pop_front();
         m_ws.a = h.a; m_ws.d = h.d;
         if (m_mcnt < 255) m_mcnt++;
      end else if (ga) begin
         m_ws.a = aa; m_ws.d = ad;
         if (m_acnt < 255) m_acnt++;
      end
      if (mv) begin
         if (mq.size() < DEPTH) mq.push_back('{a: ma, d: md});
         else m_ovf = 1'b1;
      end
      sb.push_back(m_ws);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(0, 0, '0, '0, 0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      stall = 0; alu_req = 0; mem_valid = 0;
      reset = 1'b1;
      #1;
      chk("rst_write", write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", mem_full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_data", rd_in, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // ALU only
      cycle(0, 1, 2'd2, 9'h0FF, 0, '0, '0);
      idle(2);

      // Load only
      do_reset();
      cycle(0, 0, '0, '0, 1, 2'd1, 9'h1A5);
      idle(3);

      // Contention: load, ALU, load
      do_reset();
      cycle(0, 0, '0, '0, 1, 2'd0, 9'h011);
      cycle(0, 1, 2'd3, 9'h033, 1, 2'd1, 9'h022);
      cycle(0, 1, 2'd3, 9'h033, 0, '0, '0);
      cycle(0, 0, '0, '0, 0, '0, '0);
      idle(2);

      // Full / overflow under stall, then drain
      do_reset();
      cycle(1, 0, '0, '0, 1, 2'd0, 9'h100);
      cycle(1, 0, '0, '0, 1, 2'd1, 9'h101);
      cycle(1, 0, '0, '0, 1, 2'd2, 9'h102);
      idle(4);
      chk("ovf_sticky", overflow, 1);

      // Reset mid-operation with FIFO full and a write in flight
      do_reset();
      cycle(1, 0, '0, '0, 1, 2'd0, 9'h0A0);
      cycle(1, 0, '0, '0, 1, 2'd1, 9'h0A1);
      cycle(0, 0, '0, '0, 1, 2'd2, 9'h0A2);
      @(posedge clk);
      #3;
      chk("pre_rst_write", write, 1);
      do_reset();
      idle(3);

`ifdef WB_COUNT_EN
      do_reset();
      for (int i = 0; i < 300; i++) cycle(0, 1, AW'(i), W'(i), 0, '0, '0);
      idle(1);
      chk("alu_cnt_sat", alu_cnt, 255);
      chk("mem_cnt_zero", mem_cnt, 0);
      do_reset();
      idle(1);
`endif

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(199) == 0) do_reset();
         cycle($urandom_range(7) == 0, $urandom_range(1) == 1, AW'($urandom), W'($urandom),
               $urandom_range(2) == 0, AW'($urandom), W'($urandom));
      end
      idle(4);
      @(posedge clk);
      #4;
      chk("sb_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
